// File: rtl/smpl_capture.sv
// Triggered multi-channel capture buffer: samples circulate in RAM until a trigger,
// then one DEPTH-sample frame (pretrig samples before the trigger) streams out oldest first.
module smpl_capture #(
  parameter int CH      = 2,
  parameter int DW      = 10,
  parameter int DEPTH   = 512,
  parameter int AUTO_TO = 4096,
  localparam int TCW    = (CH > 1) ? $clog2(CH) : 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clkSmpl,
  input  logic             n_reset,
  input  logic             arm,
  input  logic [1:0]       mode,
  input  logic [TCW-1:0]   trig_ch,
  input  logic [DW-1:0]    trig_level,
  input  logic [AW-1:0]    pretrig,
  input  logic [7:0]       decim,
  input  logic [CH*DW-1:0] smpl_data,
  input  logic             smpl_valid,
  output logic             busy,
  output logic             triggered,
  output logic [CH*DW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int TOW = (AUTO_TO > 0) ? $clog2(AUTO_TO + 1) : 1;
  localparam logic [TOW-1:0] TO_LIM  = TOW'(AUTO_TO);
  localparam logic [AW:0]    DEPTH_V = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_DUMP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [TCW-1:0]    trig_ch_q, trig_ch_d;
  logic [DW-1:0]     level_q, level_d;
  logic [AW-1:0]     pretrig_q, pretrig_d;
  logic [7:0]        decim_q, decim_d;
  logic [7:0]        dec_cnt_q, dec_cnt_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [TOW-1:0]    to_cnt_q, to_cnt_d;
  logic [AW-1:0]     trig_addr_q, trig_addr_d;
  logic              triggered_q, triggered_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [AW:0]       iss_cnt_q, iss_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;
  logic [CH*DW-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic [CH*DW-1:0]  mem [DEPTH];
  logic [CH*DW-1:0]  mem_rd_q;

  logic [DW-1:0]     cur;
  logic              capturing, acc, rise, fall, edge_hit, trig_now;
  logic              adv, issue, done;

  always_comb begin
    cur = '0;
    for (int c = 0; c < CH; c++)
      if (TCW'(c) == trig_ch_q) cur = smpl_data[c*DW +: DW];
  end

  assign capturing = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
  assign acc       = capturing && smpl_valid && (dec_cnt_q == 8'd0);
  // prev is meaningless until one sample has been accepted since arm
  assign rise      = prev_vld_q && (prev_q < level_q) && (cur >= level_q);
  assign fall      = prev_vld_q && (prev_q >= level_q) && (cur < level_q);

  always_comb begin
    edge_hit = 1'b0;
    case (mode_q)
      2'b00:   edge_hit = rise;
      2'b01:   edge_hit = fall;
      2'b10:   edge_hit = rise || fall;
      default: edge_hit = 1'b1;
    endcase
  end

  assign trig_now = acc && (state_q == S_WAIT) &&
                    (edge_hit || ((AUTO_TO != 0) && ((to_cnt_q + 1'b1) == TO_LIM)));

  // Read stage and output register stall together whenever the output is held
  assign adv   = !out_valid_q || out_ready;
  assign issue = (state_q == S_DUMP) && adv && (iss_cnt_q != DEPTH_V);
  assign done  = out_valid_q && out_ready && out_last_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    trig_ch_d   = trig_ch_q;
    level_d     = level_q;
    pretrig_d   = pretrig_q;
    decim_d     = decim_q;
    dec_cnt_d   = dec_cnt_q;
    wr_addr_d   = wr_addr_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    to_cnt_d    = to_cnt_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    rd_addr_d   = rd_addr_q;
    iss_cnt_d   = iss_cnt_q;
    rd_vld_d    = rd_vld_q;
    rd_last_d   = rd_last_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (capturing && smpl_valid)
      dec_cnt_d = (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;
    if (acc) begin
      wr_addr_d  = wr_addr_q + 1'b1;
      prev_d     = cur;
      prev_vld_d = 1'b1;
    end

    if (issue) begin
      rd_addr_d = rd_addr_q + 1'b1;
      iss_cnt_d = iss_cnt_q + 1'b1;
      rd_vld_d  = 1'b1;
      rd_last_d = (iss_cnt_q == DEPTH_V - 1'b1);
    end else if (adv) begin
      rd_vld_d = 1'b0;
    end
    if (adv) begin
      out_valid_d = rd_vld_q;
      out_last_d  = rd_vld_q && rd_last_q;
      if (rd_vld_q) out_data_d = mem_rd_q;
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          mode_d      = mode;
          trig_ch_d   = trig_ch;
          level_d     = trig_level;
          pretrig_d   = pretrig;
          decim_d     = decim;
          dec_cnt_d   = 8'd0;
          wr_addr_d   = '0;
          cnt_d       = '0;
          prev_vld_d  = 1'b0;
          to_cnt_d    = '0;
          iss_cnt_d   = '0;
          triggered_d = 1'b0;
          state_d     = (pretrig != '0) ? S_FILL : S_WAIT;
        end
      end
      S_FILL: begin
        if (acc) begin
          if (cnt_q == pretrig_q - 1'b1) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (acc) begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (trig_now) begin
            trig_addr_d = wr_addr_q;
            triggered_d = 1'b1;
            cnt_d       = '0;
            // DEPTH-1 pre-trigger samples leave no post-trigger span
            if (pretrig_q == {AW{1'b1}}) begin
              rd_addr_d = wr_addr_q - pretrig_q;
              state_d   = S_DUMP;
            end else begin
              state_d = S_POST;
            end
          end
        end
      end
      S_POST: begin
        if (acc) begin
          if ((cnt_q + 1'b1) == ~pretrig_q) begin
            rd_addr_d = trig_addr_q - pretrig_q;
            state_d   = S_DUMP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DUMP: begin
        if (done) begin
          state_d     = S_IDLE;
          triggered_d = 1'b0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      trig_ch_q   <= '0;
      level_q     <= '0;
      pretrig_q   <= '0;
      decim_q     <= '0;
      dec_cnt_q   <= '0;
      wr_addr_q   <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      to_cnt_q    <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      rd_addr_q   <= '0;
      iss_cnt_q   <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      trig_ch_q   <= trig_ch_d;
      level_q     <= level_d;
      pretrig_q   <= pretrig_d;
      decim_q     <= decim_d;
      dec_cnt_q   <= dec_cnt_d;
      wr_addr_q   <= wr_addr_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      to_cnt_q    <= to_cnt_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      rd_addr_q   <= rd_addr_d;
      iss_cnt_q   <= iss_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample RAM: 1-cycle synchronous read, no reset on storage
  always_ff @(posedge clkSmpl) begin
    if (acc)   mem[wr_addr_q] <= smpl_data;
    if (issue) mem_rd_q <= mem[rd_addr_q];
  end

  assign busy      = (state_q != S_IDLE);
  assign triggered = triggered_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_smpl_capture.sv
// Bench for smpl_capture: directed and randomized capture runs checked against a
// frame model built from the accepted-sample list (decimate, find trigger, slice).
module tb_smpl_capture;
  localparam int CH      = 2;
  localparam int DW      = 10;
  localparam int DEPTH   = 16;
  localparam int AUTO_TO = 32;
  localparam int PW      = CH * DW;
  localparam int MAXC    = 3000;

  logic          clkSmpl    = 1'b0;
  logic          n_reset    = 1'b0;
  logic          arm        = 1'b0;
  logic [1:0]    mode       = '0;
  logic          trig_ch    = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic [3:0]    pretrig    = '0;
  logic [7:0]    decim      = '0;
  logic [PW-1:0] smpl_data  = '0;
  logic          smpl_valid = 1'b0;
  logic          out_ready  = 1'b0;
  logic          busy, triggered, out_valid, out_last;
  logic [PW-1:0] out_data;

  smpl_capture #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .AUTO_TO(AUTO_TO)) dut (
    .clkSmpl(clkSmpl), .n_reset(n_reset), .arm(arm), .mode(mode), .trig_ch(trig_ch),
    .trig_level(trig_level), .pretrig(pretrig), .decim(decim), .smpl_data(smpl_data),
    .smpl_valid(smpl_valid), .busy(busy), .triggered(triggered), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clkSmpl = ~clkSmpl;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] fed[$];
  int            fed_cyc[$];
  logic [PW-1:0] got_data[$];
  logic          got_last[$];
  logic [PW-1:0] exp_frame[DEPTH];
  int            exp_last_idx;
  bit            exp_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int chan(input logic [PW-1:0] w, input int c);
    return int'(w[c*DW +: DW]);
  endfunction

  // kind 0: ch0 rising ramp, 1: ch1 falling ramp from 300, 2: constant 50, 3: counter, else random
  function automatic logic [PW-1:0] gen(input int kind, input int n);
    logic [DW-1:0] c0, c1;
    c0 = DW'($urandom);
    c1 = DW'($urandom);
    case (kind)
      0: c0 = DW'(10 * n);
      1: c1 = DW'(300 - 10 * n);
      2: begin c0 = DW'(50); c1 = DW'(50); end
      3: begin c0 = DW'(n); c1 = DW'(n); end
      default: ;
    endcase
    return {c1, c0};
  endfunction

  // Frame = DEPTH consecutive accepted samples starting pretrig before the trigger sample
  task automatic model(input int m, input int ch, input int lvl, input int p, input int dc);
    logic [PW-1:0] accq[$];
    int t, pr, cur;
    bit hit;
    accq.delete();
    for (int i = 0; i < fed.size(); i += dc + 1) accq.push_back(fed[i]);
    t = -1;
    for (int i = p; i < accq.size() && t < 0; i++) begin
      cur = chan(accq[i], ch);
      pr  = (i > 0) ? chan(accq[i-1], ch) : 0;
      hit = (m == 3);
      if (i > 0) begin
        if ((m == 0 || m == 2) && pr < lvl && cur >= lvl) hit = 1;
        if ((m == 1 || m == 2) && pr >= lvl && cur < lvl) hit = 1;
      end
      if (i - p + 1 == AUTO_TO) hit = 1;
      if (hit) t = i;
    end
    exp_ok = (t >= 0) && (t - p + DEPTH - 1 < accq.size());
    exp_last_idx = 0;
    if (exp_ok) begin
      for (int j = 0; j < DEPTH; j++) exp_frame[j] = accq[t - p + j];
      exp_last_idx = (t - p + DEPTH - 1) * (dc + 1);
    end
  endtask

  task automatic run(input int kind, input int m, input int ch, input int lvl, input int p,
                     input int dc, input int rdy, input bit stray, input string name);
    int n, c, first_vld_c;
    bit trig_seen, prev_stall;
    logic [PW-1:0] stall_data;
    logic stall_last;
    fed.delete(); fed_cyc.delete(); got_data.delete(); got_last.delete();
    trig_seen = 0; prev_stall = 0; first_vld_c = -1; stall_data = '0; stall_last = 0;
    mode = 2'(m); trig_ch = 1'(ch); trig_level = DW'(lvl); pretrig = 4'(p); decim = 8'(dc);
    arm = 1; smpl_valid = 0; out_ready = 0;
    @(posedge clkSmpl); #1;
    arm = 0;
    mode = 2'($urandom); trig_ch = 1'($urandom); trig_level = DW'($urandom);
    pretrig = 4'($urandom); decim = 8'($urandom);
    check({name, "_busy_after_arm"}, 32'(busy), 32'd1);
    n = 0; c = 0;
    while (got_data.size() < DEPTH && c < MAXC) begin
      if (prev_stall) begin
        check({name, "_stall_valid"}, 32'(out_valid), 32'd1);
        check({name, "_stall_data"}, 32'(out_data), 32'(stall_data));
        check({name, "_stall_last"}, 32'(out_last), 32'(stall_last));
      end
      if (triggered) trig_seen = 1;
      if (first_vld_c < 0 && out_valid) first_vld_c = c;
      case (rdy)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: out_ready = 1'($urandom);
      endcase
      prev_stall = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      smpl_valid = ($urandom_range(0, 3) != 0);
      if (smpl_valid) begin
        smpl_data = gen(kind, n);
        fed.push_back(smpl_data);
        fed_cyc.push_back(c);
        n++;
      end else begin
        smpl_data = PW'($urandom);
      end
      arm = 0;
      if (stray && c == 3) begin arm = 1; mode = 2'd3; pretrig = 4'd0; end
      if (stray && out_valid && out_ready && out_last) arm = 1;
      @(posedge clkSmpl); #1;
      c++;
    end
    arm = 0; smpl_valid = 0;
    check({name, "_words"}, 32'(got_data.size()), 32'(DEPTH));
    check({name, "_busy_clear"}, 32'(busy), 32'd0);
    check({name, "_trig_clear"}, 32'(triggered), 32'd0);
    check({name, "_valid_clear"}, 32'(out_valid), 32'd0);
    check({name, "_trig_seen"}, 32'(trig_seen), 32'd1);
    model(m, ch, lvl, p, dc);
    check({name, "_model_frame"}, 32'(exp_ok), 32'd1);
    if (exp_ok && got_data.size() == DEPTH) begin
      for (int j = 0; j < DEPTH; j++) begin
        check($sformatf("%s_w%0d", name, j), 32'(got_data[j]), 32'(exp_frame[j]));
        check($sformatf("%s_last%0d", name, j), 32'(got_last[j]), 32'(j == DEPTH - 1));
      end
      if (exp_last_idx < fed_cyc.size())
        check({name, "_dump_latency"}, 32'((first_vld_c - fed_cyc[exp_last_idx]) <= 3 &&
                                          (first_vld_c - fed_cyc[exp_last_idx]) >= 1), 32'd1);
    end
    if (got_data.size() != DEPTH) begin
      n_reset = 0; #2; n_reset = 1;
    end
    @(posedge clkSmpl); #1;
    check({name, "_still_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, c;
    repeat (2) @(posedge clkSmpl);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_triggered", 32'(triggered), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    n_reset = 1;
    @(posedge clkSmpl); #1;

    run(0, 0, 0, 100, 4, 0, 0, 0, "t1_rise");
    if (got_data.size() == DEPTH) begin
      check("t1_first_ch0", 32'(chan(got_data[0], 0)), 32'd60);
      check("t1_last_ch0", 32'(chan(got_data[DEPTH-1], 0)), 32'd210);
    end

    run(1, 1, 1, 100, 4, 0, 0, 0, "t2_fall");
    if (got_data.size() == DEPTH) begin
      check("t2_trig_ch1", 32'(chan(got_data[4], 1)), 32'd90);
      check("t2_pre_ch1", 32'(chan(got_data[3], 1)), 32'd100);
    end

    run(2, 0, 0, 100, 4, 0, 0, 0, "t3_timeout");

    run(3, 3, 0, 0, 0, 2, 0, 0, "t4_decim");
    if (got_data.size() == DEPTH) begin
      check("t4_first", 32'(chan(got_data[0], 0)), 32'd0);
      check("t4_last", 32'(chan(got_data[DEPTH-1], 0)), 32'd45);
    end

    run(4, 2, 0, 512, 7, 1, 1, 0, "t5_stall");
    run(3, 3, 1, 0, 15, 0, 1, 0, "t5_full_pre");

    // Reset pulse while collecting post-trigger samples
    mode = 2'd0; trig_ch = 1'b0; trig_level = DW'(100); pretrig = 4'd4; decim = 8'd0;
    arm = 1; smpl_valid = 0; out_ready = 1;
    @(posedge clkSmpl); #1;
    arm = 0;
    n = 0; c = 0;
    while (!triggered && c < 200) begin
      smpl_valid = 1; smpl_data = gen(0, n); n++;
      @(posedge clkSmpl); #1;
      c++;
    end
    check("t6_reached_post", 32'(triggered), 32'd1);
    smpl_data = gen(0, n); n++;
    @(posedge clkSmpl); #1;
    smpl_data = gen(0, n);
    @(posedge clkSmpl); #1;
    smpl_valid = 0;
    check("t6_busy_in_post", 32'(busy), 32'd1);
    #2 n_reset = 0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_triggered", 32'(triggered), 32'd0);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_out_last", 32'(out_last), 32'd0);
    check("t6_rst_out_data", 32'(out_data), 32'd0);
    @(posedge clkSmpl); #1;
    n_reset = 1;
    repeat (3) @(posedge clkSmpl);
    #1;
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_valid", 32'(out_valid), 32'd0);

    run(0, 0, 0, 100, 4, 0, 0, 1, "t6_stray_arm");

    for (int r = 0; r < 4; r++)
      run(4, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1023),
          $urandom_range(0, 15), $urandom_range(0, 3), 2, 0, $sformatf("rnd%0d", r));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
